// File: rtl/MD_pkg.sv
// Shared MD packet widths used by the position ring blocks.
package MD_pkg;
  localparam int GLOBAL_CELL_ID_WIDTH    = 4;
  localparam int OFFSET_WIDTH            = 16;
  localparam int OFFSET_PKT_STRUCT_WIDTH = 3 * OFFSET_WIDTH;

  typedef struct packed {
    logic [OFFSET_WIDTH-1:0] x;
    logic [OFFSET_WIDTH-1:0] y;
    logic [OFFSET_WIDTH-1:0] z;
  } offset_pkt_t;
endpackage

// File: rtl/pos_cache_feeder_if.sv
// Control, position-cache and ring-injection signals of pos_cache_feeder.
interface pos_cache_feeder_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                                         i_start;
  logic [ADDR_WIDTH:0]                          i_num_particles;
  logic [3*MD_pkg::GLOBAL_CELL_ID_WIDTH-1:0]    i_home_gcid;
  logic                                         o_rd_en;
  logic [ADDR_WIDTH-1:0]                        o_rd_addr;
  logic [MD_pkg::OFFSET_PKT_STRUCT_WIDTH-1:0]   i_rd_data;
  logic                                         i_dirty_feedback;
  logic [MD_pkg::OFFSET_PKT_STRUCT_WIDTH-1:0]   o_local_offset_pkt;
  logic [3*MD_pkg::GLOBAL_CELL_ID_WIDTH-1:0]    o_local_gcid;
  logic                                         o_local_valid;
  logic                                         o_local_dirty;
  logic                                         o_busy;
  logic                                         o_done;
  logic                                         o_protocol_err;

  modport master (
    input  i_start, i_num_particles, i_home_gcid, i_rd_data, i_dirty_feedback,
    output o_rd_en, o_rd_addr, o_local_offset_pkt, o_local_gcid,
    output o_local_valid, o_local_dirty, o_busy, o_done, o_protocol_err
  );

  modport slave (
    output i_start, i_num_particles, i_home_gcid, i_rd_data, i_dirty_feedback,
    input  o_rd_en, o_rd_addr, o_local_offset_pkt, o_local_gcid,
    input  o_local_valid, o_local_dirty, o_busy, o_done, o_protocol_err
  );
endinterface

// File: rtl/pos_cache_feeder.sv
// Streams home-cell particles from the position cache to the ring router, one at a time.
// First particle presented RD_LATENCY+2 cycles after start; a stalled router holds CUR/NXT and stops reads.
module pos_cache_feeder #(
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  pos_cache_feeder_if.master bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int PW = MD_pkg::OFFSET_PKT_STRUCT_WIDTH;
  localparam int GW = 3 * MD_pkg::GLOBAL_CELL_ID_WIDTH;

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [GW-1:0]         gcid_q, gcid_d;
  logic                  cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
  logic [PW-1:0]         cur_dat_q, cur_dat_d, nxt_dat_q, nxt_dat_d;
  logic [RD_LATENCY-1:0] sr_q, sr_d;
  logic                  landed_q, landed_d;
  logic                  err_q, err_d;

  logic rd_en, capture, consume, inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      issued_q  <= '0;
      ptr_q     <= '0;
      gcid_q    <= '0;
      cur_vld_q <= 1'b0;
      nxt_vld_q <= 1'b0;
      cur_dat_q <= '0;
      nxt_dat_q <= '0;
      sr_q      <= '0;
      landed_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      issued_q  <= issued_d;
      ptr_q     <= ptr_d;
      gcid_q    <= gcid_d;
      cur_vld_q <= cur_vld_d;
      nxt_vld_q <= nxt_vld_d;
      cur_dat_q <= cur_dat_d;
      nxt_dat_q <= nxt_dat_d;
      sr_q      <= sr_d;
      landed_q  <= landed_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    issued_d  = issued_q;
    ptr_d     = ptr_q;
    gcid_d    = gcid_q;
    cur_vld_d = cur_vld_q;
    nxt_vld_d = nxt_vld_q;
    cur_dat_d = cur_dat_q;
    nxt_dat_d = nxt_dat_q;
    sr_d      = sr_q;

    capture  = sr_q[RD_LATENCY-1];
    consume  = bus.i_dirty_feedback & cur_vld_q;
    // The cycle after a capture also counts as busy so the issue decision sees settled slots.
    inflight = (|sr_q) | landed_q;
    rd_en    = (state_q == SCAN) && (issued_q < count_q) && !inflight && !nxt_vld_q;
    landed_d = capture;
    err_d    = err_q | (bus.i_dirty_feedback & ~cur_vld_q);

    sr_d[0] = rd_en;
    for (int i = 1; i < RD_LATENCY; i++) sr_d[i] = sr_q[i-1];

    if (consume) begin
      cur_vld_d = nxt_vld_q;
      cur_dat_d = nxt_dat_q;
      nxt_vld_d = 1'b0;
    end

    if (capture) begin
      if ((!cur_vld_q || consume) && !nxt_vld_q) begin
        cur_vld_d = 1'b1;
        cur_dat_d = bus.i_rd_data;
      end else begin
        nxt_vld_d = 1'b1;
        nxt_dat_d = bus.i_rd_data;
      end
    end

    if (rd_en) begin
      ptr_d    = ptr_q + ADDR_WIDTH'(1);
      issued_d = issued_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          count_d   = bus.i_num_particles;
          gcid_d    = bus.i_home_gcid;
          ptr_d     = '0;
          issued_d  = '0;
          cur_vld_d = 1'b0;
          nxt_vld_d = 1'b0;
          sr_d      = '0;
          landed_d  = 1'b0;
          state_d   = (bus.i_num_particles == '0) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        if ((issued_q == count_q) && !inflight && !cur_vld_q && !nxt_vld_q
            && !bus.i_dirty_feedback)
          state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_rd_en            = rd_en;
  assign bus.o_rd_addr          = ptr_q;
  assign bus.o_local_offset_pkt = cur_dat_q;
  assign bus.o_local_gcid       = gcid_q;
  assign bus.o_local_valid      = cur_vld_q;
  assign bus.o_local_dirty      = bus.i_dirty_feedback | ~cur_vld_q;
  assign bus.o_busy             = (state_q != IDLE);
  assign bus.o_done             = (state_q == FINISH);
  assign bus.o_protocol_err     = err_q;
endmodule

// File: tb/tb_pos_cache_feeder.sv
// Bench for pos_cache_feeder: cache model, greedy router model and a particle scoreboard.
module tb_pos_cache_feeder;
  localparam int AW  = 7;
  localparam int RDL = 2;
  localparam int PW  = MD_pkg::OFFSET_PKT_STRUCT_WIDTH;
  localparam int GW  = 3 * MD_pkg::GLOBAL_CELL_ID_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pos_cache_feeder_if #(.ADDR_WIDTH(AW)) ifc();

  pos_cache_feeder #(.ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  bit router_en = 1'b0;
  bit force_fb = 1'b0;
  logic [PW-1:0]    mem [0:255];
  logic [PW+GW-1:0] sb [$];
  int due_q [$];
  int addr_q [$];
  int rd_cyc [$];
  int rd_addr [$];
  int take_cyc [$];
  int done_cnt, busy_cnt, first_valid;

  function automatic logic [PW-1:0] rnd_pkt();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[PW-1:0];
  endfunction

  function automatic int at(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // One clock: sample at negedge (router, cache, scoreboard), then drive #1 after posedge.
  task automatic step();
    logic             take;
    logic [PW+GW-1:0] exp_v;
    @(negedge clk);
    take = router_en && ifc.o_local_valid && !ifc.o_local_dirty;
    if (take) begin
      take_cyc.push_back(cyc - t0);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: got pkt %h gcid %h, expected no more particles",
                 ifc.o_local_offset_pkt, ifc.o_local_gcid);
      end else begin
        exp_v = sb.pop_front();
        if ({ifc.o_local_offset_pkt, ifc.o_local_gcid} !== exp_v) begin
          n_bad++;
          $display("FAIL sb_particle: got %h expected %h",
                   {ifc.o_local_offset_pkt, ifc.o_local_gcid}, exp_v);
        end
      end
    end
    if (ifc.o_rd_en) begin
      rd_cyc.push_back(cyc - t0);
      rd_addr.push_back(int'(ifc.o_rd_addr));
      due_q.push_back(cyc + RDL);
      addr_q.push_back(int'(ifc.o_rd_addr));
    end
    if (ifc.o_done) done_cnt++;
    if (ifc.o_busy) busy_cnt++;
    if (ifc.o_local_valid && first_valid < 0) first_valid = cyc - t0;
    @(posedge clk);
    #1;
    cyc++;
    ifc.i_dirty_feedback = take || force_fb;
    while (due_q.size() > 0 && due_q[0] < cyc) begin
      void'(due_q.pop_front());
      void'(addr_q.pop_front());
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      ifc.i_rd_data = mem[addr_q[0]];
      void'(due_q.pop_front());
      void'(addr_q.pop_front());
    end else begin
      ifc.i_rd_data = rnd_pkt();
    end
  endtask

  task automatic begin_scan(input int n, input logic [GW-1:0] g);
    for (int i = 0; i < n; i++) begin
      mem[i] = rnd_pkt();
      sb.push_back({mem[i], g});
    end
    rd_cyc.delete();
    rd_addr.delete();
    take_cyc.delete();
    done_cnt = 0;
    busy_cnt = 0;
    first_valid = -1;
    ifc.i_num_particles = (AW+1)'(n);
    ifc.i_home_gcid = g;
    ifc.i_start = 1'b1;
    t0 = cyc;
    step();
    ifc.i_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if ({ifc.o_local_valid, ifc.o_local_dirty, ifc.o_busy, ifc.o_done, ifc.o_rd_en,
         ifc.o_protocol_err} !== 6'b010000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 010000", {ifc.o_local_valid,
               ifc.o_local_dirty, ifc.o_busy, ifc.o_done, ifc.o_rd_en, ifc.o_protocol_err});
    end
    n_cmp++;
    if ({ifc.o_local_offset_pkt, ifc.o_local_gcid} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 0", {ifc.o_local_offset_pkt, ifc.o_local_gcid});
    end
  endtask

  task automatic test_basic_scan();
    router_en = 1'b1;
    begin_scan(3, 12'hA5C);
    run_until_done(100);
    repeat (3) step();
    n_cmp++;
    if (rd_cyc.size() != 3) begin n_bad++; $display("FAIL basic_rd_count: got %0d expected 3", rd_cyc.size()); end
    n_cmp++;
    if (at(rd_cyc, 0) != 1) begin n_bad++; $display("FAIL basic_rd_cyc0: got %0d expected 1", at(rd_cyc, 0)); end
    n_cmp++;
    if (at(rd_cyc, 1) != 5) begin n_bad++; $display("FAIL basic_rd_cyc1: got %0d expected 5", at(rd_cyc, 1)); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (at(rd_addr, i) != i) begin n_bad++; $display("FAIL basic_rd_addr%0d: got %0d expected %0d", i, at(rd_addr, i), i); end
    end
    n_cmp++;
    if (first_valid != 4) begin n_bad++; $display("FAIL basic_first_valid: got %0d expected 4", first_valid); end
    n_cmp++;
    if (take_cyc.size() != 3) begin n_bad++; $display("FAIL basic_feedbacks: got %0d expected 3", take_cyc.size()); end
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL basic_sb_left: got %0d expected 0", sb.size()); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
    n_cmp++;
    if (ifc.o_protocol_err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b expected 0", ifc.o_protocol_err); end
  endtask

  task automatic test_stalled_router();
    router_en = 1'b0;
    begin_scan(4, 12'h3C1);
    for (int i = 0; i < 20 && !ifc.o_local_valid; i++) step();
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if ({ifc.o_local_valid, ifc.o_local_dirty, ifc.o_local_offset_pkt} !== {2'b10, mem[0]}) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got v%b d%b %h expected v1 d0 %h", i, ifc.o_local_valid,
                 ifc.o_local_dirty, ifc.o_local_offset_pkt, mem[0]);
      end
    end
    n_cmp++;
    if (rd_cyc.size() != 2) begin n_bad++; $display("FAIL stall_rd_count: got %0d expected 2", rd_cyc.size()); end
    n_cmp++;
    if (at(rd_addr, 1) != 1) begin n_bad++; $display("FAIL stall_nxt_addr: got %0d expected 1", at(rd_addr, 1)); end
    router_en = 1'b1;
    run_until_done(200);
    step();
    n_cmp++;
    if (at(take_cyc, 1) - at(take_cyc, 0) != 2) begin
      n_bad++;
      $display("FAIL stall_nxt_gap: got %0d expected 2", at(take_cyc, 1) - at(take_cyc, 0));
    end
    n_cmp++;
    if (sb.size() != 0 || take_cyc.size() != 4) begin
      n_bad++;
      $display("FAIL stall_delivered: got %0d taken, %0d left expected 4 taken, 0 left", take_cyc.size(), sb.size());
    end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL stall_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_zero_particles();
    router_en = 1'b1;
    begin_scan(0, 12'h777);
    repeat (4) step();
    n_cmp++;
    if (rd_cyc.size() != 0) begin n_bad++; $display("FAIL zero_rd: got %0d expected 0", rd_cyc.size()); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
    n_cmp++;
    if (busy_cnt != 1) begin n_bad++; $display("FAIL zero_busy: got %0d expected 1", busy_cnt); end
  endtask

  task automatic test_start_while_busy();
    router_en = 1'b1;
    begin_scan(5, 12'h5A5);
    repeat (6) step();
    ifc.i_num_particles = (AW+1)'(2);
    ifc.i_home_gcid = 12'hBAD;
    ifc.i_start = 1'b1;
    step();
    ifc.i_start = 1'b0;
    run_until_done(200);
    repeat (5) step();
    n_cmp++;
    if (take_cyc.size() != 5 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL busy_start_taken: got %0d taken, %0d left expected 5 taken, 0 left", take_cyc.size(), sb.size());
    end
    n_cmp++;
    if (rd_cyc.size() != 5) begin n_bad++; $display("FAIL busy_start_rd: got %0d expected 5", rd_cyc.size()); end
    n_cmp++;
    if (done_cnt != 1 || ifc.o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_start_done: got done %0d busy %b expected 1 and 0", done_cnt, ifc.o_busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit hit;
    hit = 1'b0;
    router_en = 1'b1;
    begin_scan(8, 12'h1E2);
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      hit = (take_cyc.size() >= 2) && (due_q.size() > 0);
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL midrst_setup: got %0d taken, expected 2 with read in flight", take_cyc.size()); end
    router_en = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++;
    if ({ifc.o_local_valid, ifc.o_local_dirty, ifc.o_busy, ifc.o_done, ifc.o_rd_en,
         ifc.o_protocol_err} !== 6'b010000) begin
      n_bad++;
      $display("FAIL midrst_flags: got %b expected 010000", {ifc.o_local_valid,
               ifc.o_local_dirty, ifc.o_busy, ifc.o_done, ifc.o_rd_en, ifc.o_protocol_err});
    end
    rst = 1'b0;
    done_cnt = 0;
    first_valid = -1;
    repeat (6) step();
    n_cmp++;
    if (done_cnt != 0 || first_valid != -1) begin
      n_bad++;
      $display("FAIL midrst_quiet: got done %0d valid_at %0d expected 0 and -1", done_cnt, first_valid);
    end
    sb.delete();
    router_en = 1'b1;
    begin_scan(8, 12'h2F0);
    run_until_done(300);
    step();
    n_cmp++;
    if (at(rd_addr, 0) != 0 || at(rd_cyc, 0) != 1) begin
      n_bad++;
      $display("FAIL midrst_rescan: got addr %0d at cycle %0d expected addr 0 at cycle 1", at(rd_addr, 0), at(rd_cyc, 0));
    end
    n_cmp++;
    if (take_cyc.size() != 8 || sb.size() != 0 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL midrst_complete: got %0d taken %0d left %0d done expected 8 0 1",
               take_cyc.size(), sb.size(), done_cnt);
    end
  endtask

  task automatic test_spurious_feedback();
    router_en = 1'b0;
    force_fb = 1'b1;
    step();
    force_fb = 1'b0;
    step();
    n_cmp++;
    if ({ifc.o_protocol_err, ifc.o_busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL spur_err_set: got err %b busy %b expected 1 0", ifc.o_protocol_err, ifc.o_busy);
    end
    repeat (5) step();
    n_cmp++;
    if (ifc.o_protocol_err !== 1'b1) begin n_bad++; $display("FAIL spur_err_sticky: got %b expected 1", ifc.o_protocol_err); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (ifc.o_protocol_err !== 1'b0) begin n_bad++; $display("FAIL spur_err_clear: got %b expected 0", ifc.o_protocol_err); end
  endtask

  initial begin
    rst = 1'b1;
    ifc.i_start = 1'b0;
    ifc.i_num_particles = '0;
    ifc.i_home_gcid = '0;
    ifc.i_rd_data = '0;
    ifc.i_dirty_feedback = 1'b0;
    test_reset();
    test_basic_scan();
    test_stalled_router();
    test_zero_particles();
    test_start_while_busy();
    test_reset_mid_scan();
    test_spurious_feedback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
